sort_arbiter: RTL and testbench

Shares one registered 3-input max/mid/min sorter between two pixel requesters, A and B, which are independent RGB streams. Round-robin arbitration uses valid/ready handshakes on both inputs and the output. Results land in a small output FIFO, and the sorter only accepts a pixel when FIFO space is guaranteed, so no result is ever dropped. The block sits in front of the hue/saturation stage of the RGB-to-HSI pipeline and tags each result with its source.

---
 rtl/sort_arb_pkg.sv | 28 ++
 rtl/sort_arbiter_sort3.sv | 75 +++++++
 rtl/sort_arbiter.sv | 156 +++++++++++++++
 tb/tb_sort_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_arb_pkg.sv
// Shared types, constants and pixel-unpacking helper for the shared-sorter arbiter.
// Pixels are packed {r,g,b}, with r in the most significant component slot.
package sort_arb_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int MAX_DW     = 32;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int COMP_B = 0;
    localparam int COMP_G = 1;
    localparam int COMP_R = 2;

    // Extracts component idx (0=b, 1=g, 2=r) of width dw from a zero-extended packed pixel.
    function automatic logic [MAX_DW-1:0] unpack_comp(
        input logic [3*MAX_DW-1:0] pix,
        input int                  dw,
        input int                  idx
    );
        logic [3*MAX_DW-1:0] shifted;
        logic [MAX_DW-1:0]   mask;
        shifted = pix >> (dw * idx);
        mask    = (dw >= MAX_DW) ? '1 : ((MAX_DW'(1) << dw) - MAX_DW'(1));
        return shifted[MAX_DW-1:0] & mask;
    endfunction

endpackage

// File: rtl/sort_arbiter_sort3.sv
// Registered 3-input sorter: one cycle after ce, presents max/mid/min and the source tag.
// Equal inputs are legal; the outputs are always the input multiset in descending order.
module sort3_stage
    import sort_arb_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    input  logic          tag_in,
    output logic [DW-1:0] max_out,
    output logic [DW-1:0] mid_out,
    output logic [DW-1:0] min_out,
    output logic          tag_out,
    output logic          v_out
);

    logic [DW-1:0] hi_rg;
    logic [DW-1:0] lo_rg;
    logic [DW-1:0] max_d, max_q;
    logic [DW-1:0] mid_d, mid_q;
    logic [DW-1:0] min_d, min_q;
    logic          tag_d, tag_q;
    logic          v_d, v_q;

    // Order r/g first, then place b relative to that pair.
    always_comb begin
        hi_rg = (r >= g) ? r : g;
        lo_rg = (r >= g) ? g : r;
        max_d = max_q;
        mid_d = mid_q;
        min_d = min_q;
        tag_d = tag_q;
        v_d   = ce;
        if (ce) begin
            max_d = (hi_rg >= b) ? hi_rg : b;
            min_d = (lo_rg <= b) ? lo_rg : b;
            if (b >= hi_rg) begin
                mid_d = hi_rg;
            end else if (b <= lo_rg) begin
                mid_d = lo_rg;
            end else begin
                mid_d = b;
            end
            tag_d = tag_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
            mid_q <= '0;
            min_q <= '0;
            tag_q <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            max_q <= max_d;
            mid_q <= mid_d;
            min_q <= min_d;
            tag_q <= tag_d;
            v_q   <= v_d;
        end
    end

    assign max_out = max_q;
    assign mid_out = mid_q;
    assign min_out = min_q;
    assign tag_out = tag_q;
    assign v_out   = v_q;

endmodule

// File: rtl/sort_arbiter.sv
// Round-robin share of one registered max/mid/min sorter between two RGB requesters,
// feeding a small first-word-fall-through FIFO that is never overrun thanks to credit gating.
module sort_arbiter
    import sort_arb_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [3*DW-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [3*DW-1:0] b_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_max,
    output logic [DW-1:0]   out_mid,
    output logic [DW-1:0]   out_min,
    output logic            out_src,
    output logic            busy,
    output logic [CW-1:0]   cnt_a,
    output logic [CW-1:0]   cnt_b
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = AW + 1;

    typedef struct packed {
        logic [DW-1:0] mx;
        logic [DW-1:0] md;
        logic [DW-1:0] mn;
        logic          src;
    } entry_t;

    logic            prio_b_q, prio_b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d;
    logic [CW-1:0]   cnt_b_q, cnt_b_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]   count_q, count_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head;

    logic            grant_a, grant_b;
    logic            credit_ok;
    logic            acc_a, acc_b, accept;
    logic            push, pop;
    logic [3*DW-1:0] sel_data;
    logic [DW-1:0]   pix_r, pix_g, pix_b;
    logic [DW-1:0]   s1_max, s1_mid, s1_min;
    logic            s1_tag, s1_v;

    // Credit counts the sorter slot as occupied; a same-cycle pop is deliberately not credited.
    always_comb begin
        credit_ok = (count_q + NW'(s1_v)) < NW'(DEPTH);
        grant_a   = a_valid & (~b_valid | ~prio_b_q);
        grant_b   = b_valid & (~a_valid | prio_b_q);
        a_ready   = grant_a & credit_ok;
        b_ready   = grant_b & credit_ok;
        acc_a     = a_valid & a_ready;
        acc_b     = b_valid & b_ready;
        accept    = acc_a | acc_b;
        sel_data  = grant_b ? b_data : a_data;
        prio_b_d  = prio_b_q;
        cnt_a_d   = cnt_a_q;
        cnt_b_d   = cnt_b_q;
        if (acc_a) begin
            prio_b_d = 1'b1;
            cnt_a_d  = cnt_a_q + CW'(1);
        end else if (acc_b) begin
            prio_b_d = 1'b0;
            cnt_b_d  = cnt_b_q + CW'(1);
        end
    end

    assign pix_r = DW'(unpack_comp((3*MAX_DW)'(sel_data), DW, COMP_R));
    assign pix_g = DW'(unpack_comp((3*MAX_DW)'(sel_data), DW, COMP_G));
    assign pix_b = DW'(unpack_comp((3*MAX_DW)'(sel_data), DW, COMP_B));

    sort3_stage #(
        .DW (DW)
    ) u_sort3 (
        .clk     (clk),
        .rst     (rst),
        .ce      (accept),
        .r       (pix_r),
        .g       (pix_g),
        .b       (pix_b),
        .tag_in  (acc_b ? SRC_B : SRC_A),
        .max_out (s1_max),
        .mid_out (s1_mid),
        .min_out (s1_min),
        .tag_out (s1_tag),
        .v_out   (s1_v)
    );

    // Every sorter result is pushed the cycle it appears; credit guarantees room for it.
    always_comb begin
        push     = s1_v;
        pop      = (count_q != '0) & out_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{mx: s1_max, md: s1_mid, mn: s1_min, src: s1_tag};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_b_q <= 1'b0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            prio_b_q <= prio_b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_max   = head.mx;
    assign out_mid   = head.md;
    assign out_min   = head.mn;
    assign out_src   = head.src;
    assign busy      = s1_v | (count_q != '0);
    assign cnt_a     = cnt_a_q;
    assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_sort_arbiter.sv
// Self-checking bench for sort_arbiter: directed corner sequences, a sort-vector table and
// randomized traffic checked every cycle against a queue-based reference model.
module tb_sort_arbiter;

    localparam int DW       = 8;
    localparam int DEPTH    = 2;
    localparam int CW       = 4;
    localparam int CNT_MASK = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_valid, b_valid, out_ready;
    logic            a_ready, b_ready, out_valid, out_src, busy;
    logic [3*DW-1:0] a_data, b_data;
    logic [DW-1:0]   out_max, out_mid, out_min;
    logic [CW-1:0]   cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sort_arbiter #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_mid   (out_mid),
        .out_min   (out_min),
        .out_src   (out_src),
        .busy      (busy),
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] mx;
        logic [7:0] md;
        logic [7:0] mn;
        logic       src;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       src;
        logic [7:0] e_max;
        logic [7:0] e_mid;
        logic [7:0] e_min;
    } vec_t;

    exp_t exp_q[$];
    exp_t hd;
    exp_t ne;
    logic m_prio_b = 1'b0;
    int   m_cnt_a  = 0;
    int   m_cnt_b  = 0;
    logic mg_a, mg_b, m_credit, m_ov;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [3*DW-1:0] ad,
                                 input logic bv, input logic [3*DW-1:0] bd, input logic ordy);
        a_valid   = av;
        a_data    = ad;
        b_valid   = bv;
        b_data    = bd;
        out_ready = ordy;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleEdge();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        rst = 1'b0;
    endtask

    // Reference ordering: plain descending sort of the three components.
    function automatic void sort_ref(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z,
                                     output logic [7:0] hi, output logic [7:0] md, output logic [7:0] lo);
        logic [7:0] v[3];
        logic [7:0] t;
        v[0] = x;
        v[1] = y;
        v[2] = z;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2 - i; j++) begin
                if (v[j] < v[j+1]) begin
                    t      = v[j];
                    v[j]   = v[j+1];
                    v[j+1] = t;
                end
            end
        end
        hi = v[0];
        md = v[1];
        lo = v[2];
    endfunction

    function automatic logic [7:0] rand_comp();
        if ($urandom_range(0, 1) == 0) return 8'($urandom);
        return 8'($urandom_range(5, 7));
    endfunction

    function automatic logic [3*DW-1:0] rand_pix();
        return {rand_comp(), rand_comp(), rand_comp()};
    endfunction

    // Reference model: items in flight form a queue; each becomes visible two cycles after
    // its accept, credit is "fewer than DEPTH items in flight", and grants alternate on ties.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            m_prio_b = 1'b0;
            m_cnt_a  = 0;
            m_cnt_b  = 0;
            checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_cnt_a", 32'(cnt_a), 32'd0);
            checkOutput("rst_cnt_b", 32'(cnt_b), 32'd0);
            checkOutput("rst_out_max", 32'(out_max), 32'd0);
            checkOutput("rst_out_src", 32'(out_src), 32'd0);
        end else begin
            m_credit = (exp_q.size() < DEPTH);
            mg_a     = a_valid && (!b_valid || !m_prio_b);
            mg_b     = b_valid && (!a_valid || m_prio_b);
            m_ov     = (exp_q.size() > 0) && (exp_q[0].cyc + 2 <= cyc);
            checkOutput("a_ready", 32'(a_ready), 32'(mg_a && m_credit));
            checkOutput("b_ready", 32'(b_ready), 32'(mg_b && m_credit));
            checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
            checkOutput("busy", 32'(busy), 32'(exp_q.size() != 0));
            checkOutput("cnt_a", 32'(cnt_a), 32'(m_cnt_a));
            checkOutput("cnt_b", 32'(cnt_b), 32'(m_cnt_b));
            if (m_ov && out_ready) begin
                hd = exp_q.pop_front();
                checkOutput("sb_out_max", 32'(out_max), 32'(hd.mx));
                checkOutput("sb_out_mid", 32'(out_mid), 32'(hd.md));
                checkOutput("sb_out_min", 32'(out_min), 32'(hd.mn));
                checkOutput("sb_out_src", 32'(out_src), 32'(hd.src));
            end
            if (m_credit && (mg_a || mg_b)) begin
                if (mg_a) sort_ref(a_data[23:16], a_data[15:8], a_data[7:0], ne.mx, ne.md, ne.mn);
                else      sort_ref(b_data[23:16], b_data[15:8], b_data[7:0], ne.mx, ne.md, ne.mn);
                ne.src = mg_b;
                ne.cyc = cyc;
                exp_q.push_back(ne);
                m_prio_b = mg_a;
                if (mg_a) m_cnt_a = (m_cnt_a + 1) & CNT_MASK;
                else      m_cnt_b = (m_cnt_b + 1) & CNT_MASK;
            end
        end
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    vec_t vecs[9];
    int   n_acc;
    int   n_more;
    logic exp_src;
    logic took_a, took_b;

    initial begin
        vecs[0] = '{8'd200, 8'd50,  8'd120, 1'b0, 8'd200, 8'd120, 8'd50};
        vecs[1] = '{8'd77,  8'd77,  8'd77,  1'b0, 8'd77,  8'd77,  8'd77};
        vecs[2] = '{8'd10,  8'd200, 8'd10,  1'b0, 8'd200, 8'd10,  8'd10};
        vecs[3] = '{8'd0,   8'd255, 8'd128, 1'b1, 8'd255, 8'd128, 8'd0};
        vecs[4] = '{8'd255, 8'd255, 8'd0,   1'b1, 8'd255, 8'd255, 8'd0};
        vecs[5] = '{8'd1,   8'd2,   8'd3,   1'b0, 8'd3,   8'd2,   8'd1};
        vecs[6] = '{8'd3,   8'd2,   8'd1,   1'b1, 8'd3,   8'd2,   8'd1};
        vecs[7] = '{8'd9,   8'd9,   8'd200, 1'b1, 8'd200, 8'd9,   8'd9};
        vecs[8] = '{8'd5,   8'd0,   8'd5,   1'b0, 8'd5,   8'd5,   8'd0};

        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        sampleEdge();
        checkOutput("init_out_valid", 32'(out_valid), 32'd0);
        checkOutput("init_busy", 32'(busy), 32'd0);
        checkOutput("init_cnt_a", 32'(cnt_a), 32'd0);
        nextCycle();
        rst = 1'b0;

        // A alone: two-cycle latency, then idle again.
        applyStimulus(1'b1, {8'd200, 8'd50, 8'd120}, 1'b0, '0, 1'b1);
        sampleEdge();
        checkOutput("t1_a_ready", 32'(a_ready), 32'd1);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        sampleEdge();
        checkOutput("t1_c1_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_c1_busy", 32'(busy), 32'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t1_c2_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_c2_max", 32'(out_max), 32'd200);
        checkOutput("t1_c2_mid", 32'(out_mid), 32'd120);
        checkOutput("t1_c2_min", 32'(out_min), 32'd50);
        checkOutput("t1_c2_src", 32'(out_src), 32'd0);
        checkOutput("t1_c2_cnt_a", 32'(cnt_a), 32'd1);
        nextCycle();
        sampleEdge();
        checkOutput("t1_c3_busy", 32'(busy), 32'd0);
        checkOutput("t1_c3_cnt_a", 32'(cnt_a), 32'd1);
        checkOutput("t1_c3_out_valid", 32'(out_valid), 32'd0);
        nextCycle();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].src) applyStimulus(1'b0, '0, 1'b1, {vecs[i].r, vecs[i].g, vecs[i].b}, 1'b1);
            else             applyStimulus(1'b1, {vecs[i].r, vecs[i].g, vecs[i].b}, 1'b0, '0, 1'b1);
            sampleEdge();
            nextCycle();
            applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
            sampleEdge();
            nextCycle();
            sampleEdge();
            checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("vec%0d_max", i), 32'(out_max), 32'(vecs[i].e_max));
            checkOutput($sformatf("vec%0d_mid", i), 32'(out_mid), 32'(vecs[i].e_mid));
            checkOutput($sformatf("vec%0d_min", i), 32'(out_min), 32'(vecs[i].e_min));
            checkOutput($sformatf("vec%0d_src", i), 32'(out_src), 32'(vecs[i].src));
            nextCycle();
        end

        // Both requesters always valid: accepts must alternate starting with A.
        doReset();
        applyStimulus(1'b1, {8'd11, 8'd22, 8'd33}, 1'b1, {8'd99, 8'd88, 8'd77}, 1'b1);
        n_acc   = 0;
        exp_src = 1'b0;
        for (int k = 0; k < 40 && n_acc < 8; k++) begin
            sampleEdge();
            took_a = a_ready;
            took_b = b_ready;
            checkOutput("t2_single_ready", 32'(took_a & took_b), 32'd0);
            if (took_a || took_b) begin
                checkOutput("t2_order", 32'(took_b), 32'(exp_src));
                exp_src = ~exp_src;
                n_acc++;
            end
            nextCycle();
            if (took_a) a_data = a_data + 24'h010203;
            if (took_b) b_data = b_data - 24'h030201;
        end
        checkOutput("t2_accepts", 32'(n_acc), 32'd8);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        sampleEdge();
        checkOutput("t2_cnt_a", 32'(cnt_a), 32'd4);
        checkOutput("t2_cnt_b", 32'(cnt_b), 32'd4);
        repeat (4) nextCycle();

        // Downstream stalled: only DEPTH pixels get in, one pop frees exactly one slot.
        doReset();
        applyStimulus(1'b1, {8'd40, 8'd30, 8'd20}, 1'b1, {8'd1, 8'd100, 8'd50}, 1'b0);
        n_acc = 0;
        repeat (6) begin
            sampleEdge();
            if (a_ready || b_ready) n_acc++;
            nextCycle();
        end
        checkOutput("t3_accepts", 32'(n_acc), 32'd2);
        sampleEdge();
        checkOutput("t3_full_a_ready", 32'(a_ready), 32'd0);
        checkOutput("t3_full_b_ready", 32'(b_ready), 32'd0);
        nextCycle();
        out_ready = 1'b1;
        sampleEdge();
        checkOutput("t3_pop_valid", 32'(out_valid), 32'd1);
        checkOutput("t3_pop_no_ready", 32'(a_ready | b_ready), 32'd0);
        nextCycle();
        out_ready = 1'b0;
        sampleEdge();
        checkOutput("t3_refill", 32'(a_ready | b_ready), 32'd1);
        nextCycle();
        n_more = 0;
        repeat (4) begin
            sampleEdge();
            if (a_ready || b_ready) n_more++;
            nextCycle();
        end
        checkOutput("t3_no_more", 32'(n_more), 32'd0);

        // Reset while the sorter and the FIFO each hold a pixel.
        doReset();
        applyStimulus(1'b1, {8'd5, 8'd6, 8'd7}, 1'b0, '0, 1'b0);
        sampleEdge();
        nextCycle();
        applyStimulus(1'b1, {8'd8, 8'd9, 8'd10}, 1'b0, '0, 1'b0);
        sampleEdge();
        nextCycle();
        sampleEdge();
        checkOutput("t4_pre_busy", 32'(busy), 32'd1);
        checkOutput("t4_pre_out_valid", 32'(out_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("t4_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t4_rst_busy", 32'(busy), 32'd0);
        checkOutput("t4_rst_cnt_a", 32'(cnt_a), 32'd0);
        checkOutput("t4_rst_cnt_b", 32'(cnt_b), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b1, {8'd1, 8'd1, 8'd2}, 1'b1, {8'd3, 8'd3, 8'd4}, 1'b1);
        sampleEdge();
        checkOutput("t4_first_tie_a", 32'(a_ready), 32'd1);
        checkOutput("t4_first_tie_b", 32'(b_ready), 32'd0);
        nextCycle();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (4) nextCycle();

        // Counter wrap: 17 accepts from A on a 4-bit counter leave 1.
        doReset();
        applyStimulus(1'b1, {8'd60, 8'd61, 8'd62}, 1'b0, '0, 1'b1);
        n_acc = 0;
        for (int k = 0; k < 100 && n_acc < 17; k++) begin
            sampleEdge();
            took_a = a_ready;
            if (took_a) n_acc++;
            nextCycle();
            if (took_a) a_data = a_data + 24'h000101;
            if (n_acc == 17) a_valid = 1'b0;
        end
        checkOutput("t5_accepts", 32'(n_acc), 32'd17);
        sampleEdge();
        checkOutput("t5_cnt_a_wrap", 32'(cnt_a), 32'd1);
        checkOutput("t5_cnt_b", 32'(cnt_b), 32'd0);
        nextCycle();
        repeat (4) nextCycle();

        // Random traffic; requesters hold data until accepted.
        doReset();
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            sampleEdge();
            took_a = a_valid & a_ready;
            took_b = b_valid & b_ready;
            nextCycle();
            if (!a_valid || took_a) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_data  = rand_pix();
            end
            if (!b_valid || took_b) begin
                b_valid = ($urandom_range(0, 3) != 0);
                b_data  = rand_pix();
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (6) nextCycle();
        sampleEdge();
        checkOutput("drain_busy", 32'(busy), 32'd0);
        checkOutput("drain_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
